// File: rtl/mem_arbiter.sv
// Multi-channel byte-bus arbiter: grants one of NCH requesters, serialises its 1-4 byte
// little-endian transfer onto the 8-bit RAM/I-O bus and returns a one-cycle done pulse.
module mem_arbiter #(
    parameter int NCH     = 2,
    parameter int ADDR_W  = 32,
    parameter int RR_MODE = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [NCH-1:0]        req_i,
    input  logic [NCH-1:0]        we_i,
    input  logic [2*NCH-1:0]      len_i,
    input  logic [ADDR_W*NCH-1:0] addr_i,
    input  logic [32*NCH-1:0]     wdata_i,
    output logic [NCH-1:0]        gnt_o,
    output logic [NCH-1:0]        done_o,
    output logic [31:0]           rdata_o,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_W-1:0]     mem_a,
    output logic                  mem_wr
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        icnt_q, icnt_d;
    logic              pend_q, pend_d;
    logic [1:0]        pidx_q, pidx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [NCH-1:0]    gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [1:0]        len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  sel_idx;
    logic [NCH-1:0]    sel_oh;
    logic              sel_we;
    logic [1:0]        sel_len;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              issue;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        cur_byte;

    // Scan from the far end so the candidate closest to the start point wins.
    always_comb begin
        cand    = '0;
        sel_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (RR_MODE != 0) begin
                cand = IDX_W'((int'(ptr_q) + i) % NCH);
            end else begin
                cand = IDX_W'(i);
            end
            if (req_i[cand]) begin
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        sel_oh    = '0;
        sel_we    = 1'b0;
        sel_len   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int j = 0; j < NCH; j++) begin
            if (IDX_W'(j) == sel_idx) begin
                sel_oh[j] = 1'b1;
                sel_we    = we_i[j];
                sel_len   = len_i[2*j +: 2];
                sel_addr  = addr_i[ADDR_W*j +: ADDR_W];
                sel_wdata = wdata_i[32*j +: 32];
            end
        end
    end

    assign issue    = (state_q == StBusy) && rdy_in && (icnt_q <= {1'b0, len_q});
    assign cur_addr = addr_q + ADDR_W'(icnt_q);
    assign cur_byte = wdata_q[{icnt_q[1:0], 3'b000} +: 8];

    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        pend_d  = 1'b0;
        pidx_d  = pidx_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        len_d   = len_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_a_d = mem_a_q;

        // Read data always lands the cycle after its issue, paused or not.
        if (pend_q) begin
            if (pidx_q == 2'd0) begin
                rdata_d = '0;
            end
            rdata_d[{pidx_q, 3'b000} +: 8] = mem_din;
        end

        unique case (state_q)
            StIdle: begin
                if (rdy_in && (|req_i)) begin
                    we_d    = sel_we;
                    len_d   = sel_len;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    gnt_d   = sel_oh;
                    icnt_d  = '0;
                    mem_a_d = '0;
                    state_d = StBusy;
                    if (RR_MODE != 0) begin
                        ptr_d = IDX_W'((int'(sel_idx) + 1) % NCH);
                    end
                end
            end
            StBusy: begin
                if (issue) begin
                    icnt_d  = icnt_q + 3'd1;
                    mem_a_d = cur_addr;
                    if (we_q) begin
                        if (icnt_q[1:0] == len_q) begin
                            state_d = StDone;
                        end
                    end else begin
                        pend_d = 1'b1;
                        pidx_d = icnt_q[1:0];
                    end
                end
                if (!we_q && pend_q && (pidx_q == len_q)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= StIdle;
            icnt_q  <= '0;
            pend_q  <= 1'b0;
            pidx_q  <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            len_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mem_a_q <= '0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            pend_q  <= pend_d;
            pidx_q  <= pidx_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mem_a_q <= mem_a_d;
        end
    end

    always_comb begin
        gnt_o    = gnt_q;
        done_o   = (state_q == StDone) ? gnt_q : '0;
        rdata_o  = rdata_q;
        mem_wr   = issue && we_q;
        mem_dout = (issue && we_q) ? cur_byte : 8'h00;
        // A paused bus keeps showing the last issued address.
        if (issue) begin
            mem_a = cur_addr;
        end else if (state_q == StBusy) begin
            mem_a = mem_a_q;
        end else begin
            mem_a = '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one fixed-priority and one round-robin instance share the
// requester inputs and a small RAM/I-O model.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [3:0]  len_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [1:0]  gnt_o, done_o;
    logic [31:0] rdata_o;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [1:0]  gnt_rr, done_rr;
    logic [31:0] rdata_rr;
    logic [7:0]  mem_dout_rr;
    logic [31:0] mem_a_rr;
    logic        mem_wr_rr;

    int n_chk = 0;
    int n_ok = 0;
    int wr_cnt = 0;
    int io_cnt = 0;
    logic [31:0] prev_a = '0;
    logic [7:0]  ram [0:4095];

    always #5 clk_in = ~clk_in;

    mem_arbiter #(.NCH(2), .ADDR_W(32), .RR_MODE(0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req_i(req_i), .we_i(we_i),
        .len_i(len_i), .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .done_o(done_o),
        .rdata_o(rdata_o), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr)
    );

    mem_arbiter #(.NCH(2), .ADDR_W(32), .RR_MODE(1)) dut_rr (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req_i(req_i), .we_i(we_i),
        .len_i(len_i), .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_rr), .done_o(done_rr),
        .rdata_o(rdata_rr), .mem_din(mem_din), .mem_dout(mem_dout_rr), .mem_a(mem_a_rr),
        .mem_wr(mem_wr_rr)
    );

    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        case (a)
            32'h100:   rom_byte = 8'h11;
            32'h101:   rom_byte = 8'h22;
            32'h102:   rom_byte = 8'h33;
            32'h103:   rom_byte = 8'h44;
            32'h30000: rom_byte = 8'h41;
            default:   rom_byte = ram[a[11:0]];
        endcase
    endfunction

    always @(posedge clk_in) begin
        if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
            wr_cnt <= wr_cnt + 1;
        end
        mem_din <= rom_byte(mem_a);
        if (mem_a == 32'h30000 && prev_a != 32'h30000) io_cnt <= io_cnt + 1;
        prev_a <= mem_a;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; req_i = '0; we_i = '0; len_i = '0;
        addr_i = '0; wdata_i = '0;
        tick(); tick();
        n_chk++; if (gnt_o !== 2'b00) $display("FAIL rst_gnt got %b want 00", gnt_o); else n_ok++;
        n_chk++; if (done_o !== 2'b00) $display("FAIL rst_done got %b want 00", done_o); else n_ok++;
        n_chk++; if (rdata_o !== 32'h0) $display("FAIL rst_rdata got %h want 0", rdata_o); else n_ok++;
        n_chk++;
        if ({mem_wr, mem_a, mem_dout} !== 41'h0)
            $display("FAIL rst_bus got wr=%b a=%h d=%h want all 0", mem_wr, mem_a, mem_dout);
        else n_ok++;
        rst_in = 1'b1;
        tick();
    endtask

    task automatic test_read4();
        tick();
        req_i = 2'b01; we_i = 2'b00; len_i = 4'b0011; addr_i = {32'h0, 32'h100};
        #1;
        n_chk++; if (gnt_o !== 2'b00) $display("FAIL rd4_c0_gnt got %b want 00", gnt_o); else n_ok++;
        for (int k = 1; k <= 4; k++) begin
            tick(); #1;
            n_chk++;
            if ({mem_wr, mem_a} !== {1'b0, 32'h100 + 32'(k - 1)})
                $display("FAIL rd4_issue%0d got wr=%b a=%h want wr=0 a=%h", k, mem_wr, mem_a,
                         32'h100 + 32'(k - 1));
            else n_ok++;
            if (k == 1) begin
                n_chk++;
                if (gnt_o !== 2'b01) $display("FAIL rd4_gnt got %b want 01", gnt_o); else n_ok++;
            end
        end
        tick(); #1;
        n_chk++; if (done_o !== 2'b00) $display("FAIL rd4_c5_done got %b want 00", done_o); else n_ok++;
        tick(); #1;
        n_chk++; if (done_o !== 2'b01) $display("FAIL rd4_done got %b want 01", done_o); else n_ok++;
        n_chk++;
        if (rdata_o !== 32'h44332211) $display("FAIL rd4_rdata got %h want 44332211", rdata_o);
        else n_ok++;
        req_i = 2'b00;
        tick(); #1;
        n_chk++;
        if ({done_o, gnt_o} !== 4'b0) $display("FAIL rd4_after got done=%b gnt=%b want 0", done_o, gnt_o);
        else n_ok++;
    endtask

    task automatic test_write2();
        int base;
        tick();
        base = wr_cnt;
        req_i = 2'b10; we_i = 2'b10; len_i = 4'b0100; addr_i = {32'h200, 32'h0};
        wdata_i = {32'h0000BEEF, 32'h0};
        #1;
        tick(); #1;
        n_chk++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h200, 8'hEF})
            $display("FAIL wr2_b0 got wr=%b a=%h d=%h want 1/200/ef", mem_wr, mem_a, mem_dout);
        else n_ok++;
        tick(); #1;
        n_chk++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h201, 8'hBE})
            $display("FAIL wr2_b1 got wr=%b a=%h d=%h want 1/201/be", mem_wr, mem_a, mem_dout);
        else n_ok++;
        tick(); #1;
        n_chk++;
        if ({done_o, mem_wr} !== 3'b100)
            $display("FAIL wr2_done got done=%b wr=%b want 10/0", done_o, mem_wr);
        else n_ok++;
        req_i = 2'b00;
        tick(); #1;
        n_chk++;
        if (wr_cnt - base != 2) $display("FAIL wr2_count got %0d want 2", wr_cnt - base); else n_ok++;
        n_chk++;
        if ({ram[12'h200], ram[12'h201]} !== 16'hEFBE)
            $display("FAIL wr2_ram got %h%h want efbe", ram[12'h200], ram[12'h201]);
        else n_ok++;
    endtask

    task automatic test_priority();
        logic [1:0] got_fix [8];
        logic [1:0] got_rr [8];
        int nd = 0;
        int nr = 0;
        for (int i = 0; i < 8; i++) begin
            got_fix[i] = '0; got_rr[i] = '0;
        end
        tick();
        req_i = 2'b11; we_i = 2'b00; len_i = 4'b0000; addr_i = {32'h101, 32'h100};
        #1;
        for (int c = 1; c <= 16; c++) begin
            tick(); #1;
            if (done_o != 2'b00) begin
                if (nd < 8) got_fix[nd] = done_o;
                nd++;
            end
            if (done_rr != 2'b00) begin
                if (nr < 8) got_rr[nr] = done_rr;
                nr++;
            end
        end
        req_i = 2'b00;
        n_chk++; if (nd != 4) $display("FAIL fix_count got %0d want 4", nd); else n_ok++;
        n_chk++; if (nr != 4) $display("FAIL rr_count got %0d want 4", nr); else n_ok++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (got_fix[i] !== 2'b01) $display("FAIL fix_grant%0d got %b want 01", i, got_fix[i]);
            else n_ok++;
            n_chk++;
            if (got_rr[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10))
                $display("FAIL rr_grant%0d got %b want %b", i, got_rr[i],
                         (i % 2 == 0) ? 2'b01 : 2'b10);
            else n_ok++;
        end
    endtask

    task automatic test_pause();
        tick();
        req_i = 2'b01; we_i = 2'b00; len_i = 4'b0011; addr_i = {32'h0, 32'h100};
        #1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 3) rdy_in = 1'b0;
            if (c == 6) rdy_in = 1'b1;
            #1;
            if (c == 1 || c == 2 || c == 6 || c == 7) begin
                n_chk++;
                if ({mem_wr, mem_a} !== {1'b0, 32'h100 + 32'((c < 3) ? c - 1 : c - 4)})
                    $display("FAIL pause_issue_c%0d got wr=%b a=%h", c, mem_wr, mem_a);
                else n_ok++;
            end else if (c >= 3 && c <= 5) begin
                n_chk++;
                if ({mem_wr, mem_a} !== {1'b0, 32'h101})
                    $display("FAIL pause_hold_c%0d got wr=%b a=%h want 0/101", c, mem_wr, mem_a);
                else n_ok++;
            end else if (c == 8) begin
                n_chk++;
                if (done_o !== 2'b00) $display("FAIL pause_early_done got %b want 00", done_o);
                else n_ok++;
            end else begin
                n_chk++;
                if (done_o !== 2'b01) $display("FAIL pause_done got %b want 01", done_o); else n_ok++;
                n_chk++;
                if (rdata_o !== 32'h44332211)
                    $display("FAIL pause_rdata got %h want 44332211", rdata_o);
                else n_ok++;
            end
        end
        req_i = 2'b00;
    endtask

    task automatic test_io();
        int base;
        tick();
        base = io_cnt;
        req_i = 2'b10; we_i = 2'b00; len_i = 4'b0000; addr_i = {32'h30000, 32'h0};
        #1;
        tick(); #1;
        n_chk++;
        if ({mem_wr, mem_a} !== {1'b0, 32'h30000})
            $display("FAIL io_issue got wr=%b a=%h want 0/30000", mem_wr, mem_a);
        else n_ok++;
        tick(); #1;
        n_chk++; if (done_o !== 2'b00) $display("FAIL io_early_done got %b want 00", done_o); else n_ok++;
        tick(); #1;
        n_chk++; if (done_o !== 2'b10) $display("FAIL io_done got %b want 10", done_o); else n_ok++;
        n_chk++;
        if (rdata_o !== 32'h00000041) $display("FAIL io_rdata got %h want 00000041", rdata_o);
        else n_ok++;
        req_i = 2'b00;
        tick(); #1;
        n_chk++;
        if (io_cnt - base != 1) $display("FAIL io_accesses got %0d want 1", io_cnt - base); else n_ok++;
    endtask

    task automatic test_reset_mid();
        int base;
        logic [31:0] wd;
        wd = 32'hDDCCBBAA;
        tick();
        base = wr_cnt;
        req_i = 2'b01; we_i = 2'b01; len_i = 4'b0011; addr_i = {32'h0, 32'h200};
        wdata_i = {32'h0, wd};
        #1;
        tick(); tick();
        tick();
        rst_in = 1'b0;
        #1;
        n_chk++;
        if ({gnt_o, done_o} !== 4'b0) $display("FAIL rstm_ctl got gnt=%b done=%b want 0", gnt_o, done_o);
        else n_ok++;
        n_chk++;
        if ({mem_wr, mem_a, mem_dout} !== 41'h0)
            $display("FAIL rstm_bus got wr=%b a=%h d=%h want 0", mem_wr, mem_a, mem_dout);
        else n_ok++;
        n_chk++; if (rdata_o !== 32'h0) $display("FAIL rstm_rdata got %h want 0", rdata_o); else n_ok++;
        for (int c = 0; c < 2; c++) begin
            tick(); #1;
            n_chk++;
            if (done_o !== 2'b00) $display("FAIL rstm_nodone%0d got %b want 00", c, done_o); else n_ok++;
        end
        tick();
        rst_in = 1'b1;
        #1;
        for (int k = 1; k <= 4; k++) begin
            tick(); #1;
            n_chk++;
            if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h200 + 32'(k - 1), wd[8*(k-1) +: 8]})
                $display("FAIL rstm_wr%0d got wr=%b a=%h d=%h", k, mem_wr, mem_a, mem_dout);
            else n_ok++;
        end
        tick(); #1;
        n_chk++; if (done_o !== 2'b01) $display("FAIL rstm_done got %b want 01", done_o); else n_ok++;
        req_i = 2'b00;
        tick(); #1;
        n_chk++;
        if (wr_cnt - base != 6) $display("FAIL rstm_count got %0d want 6", wr_cnt - base); else n_ok++;
        n_chk++;
        if ({ram[12'h202], ram[12'h203]} !== 16'hCCDD)
            $display("FAIL rstm_ram got %h%h want ccdd", ram[12'h202], ram[12'h203]);
        else n_ok++;
    endtask

    initial begin
        test_reset();
        test_read4();
        test_write2();
        test_priority();
        test_pause();
        test_io();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised successor to the two-client byte-bus memory controller. It arbitrates NCH requesters (instruction fetch, data load/store, future prefetch or I/O clients) onto the single 8-bit RAM/I-O bus.
- Each requester issues a 1–4 byte little-endian transfer. The arbiter serialises the transfer into byte accesses, assembles read data, and returns a one-cycle done pulse.
- Supports fixed or round-robin priority and honours the rdy_in pause.

Parameters:
- NCH, 2, number of requester channels (1..8).
- ADDR_W, 32, address width on requesters and bus.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous reset, active-low.
- rdy_in  in  1  global ready; low freezes new bus issues.
- req_i  in  NCH  per-channel request, held until that channel's done_o.
- we_i  in  NCH  per-channel 1 = write, 0 = read.
- len_i  in  2*NCH  per-channel byte count minus 1 (0..3).
- addr_i  in  ADDR_W*NCH  per-channel start byte address.
- wdata_i  in  32*NCH  per-channel write data, byte 0 = bits 7:0.
- gnt_o  out  NCH  one-hot; the channel currently owning the bus.
- done_o  out  NCH  one-cycle pulse on the owning channel when the transfer completes.
- rdata_o  out  32  assembled read data, zero-extended above len; valid while done_o is high.
- mem_din  in  8  RAM/I-O read data, valid the cycle after its address.
- mem_dout  out  8  write byte.
- mem_a  out  ADDR_W  byte address.
- mem_wr  out  1  1 = write, 0 = read.

Behaviour:
- Reset (async, rst_in low):
  - Outputs: gnt_o=0, done_o=0, rdata_o=0, mem_a=0, mem_dout=0, mem_wr=0.
  - Internal: state=IDLE, issue counter icnt=0, pending-capture flag pend=0, RR pointer=0.
  - Reset mid-transfer abandons the transfer; no done_o is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Bus idle (mem_a=0, mem_wr=0).
  - If rdy_in=1 and any req_i is high, select a channel:
    - RR_MODE=0: lowest set index.
    - RR_MODE=1: first set index at or after the RR pointer, wrapping modulo NCH.
  - On selection:
    - Latch that channel's we, len, addr, wdata.
    - Set gnt_o one-hot, icnt=0, go to BUSY.
    - RR_MODE=1 only: the pointer becomes granted index+1 mod NCH.
- BUSY, issue:
  - Each cycle with rdy_in=1 and icnt<=len, drive mem_a=addr+icnt (ADDR_W wrap) and mem_wr=we.
  - mem_dout = wdata byte icnt for writes, 0 for reads.
  - Then increment icnt; for reads also set pend and record the byte index.
- BUSY, pause:
  - rdy_in=0: no issue, mem_wr forced 0, mem_a holds its last value, icnt frozen.
  - Consequence: a paused write is never duplicated (matters for I/O output at 0x30000).
- BUSY, capture:
  - Whenever pend=1 at the start of a cycle, mem_din is stored into rdata byte[recorded index] and pend is cleared, regardless of rdy_in.
  - This occurs in the cycle after each issue, so no read is ever re-issued (I/O input 0x30000 is read exactly once per byte).
- Completion:
  - Write: after the last byte issue, go to DONE.
  - Read: after the last byte's capture, go to DONE.
  - DONE lasts one cycle: done_o[granted]=1 and rdata_o is valid (bytes above len are 0). Then gnt_o=0 and state returns to IDLE.
  - Completion timing is independent of rdy_in.
- Latency with no pause:
  - Read of n bytes: grant in IDLE cycle 0, issues cycles 1..n, last capture cycle n+1, done_o in cycle n+2.
  - Write of n bytes: done_o in cycle n+1.
  - Minimum gap between back-to-back transfers is one IDLE cycle.
- Requester rules:
  - A requester lowering req_i before done does not abort the transfer; done_o still pulses.
  - Requester fields are sampled only at grant; later changes are ignored.
- Simultaneous requests:
  - Exactly one channel is granted.
  - Losers keep req_i high and are served later.
  - RR_MODE=1 guarantees each waiting channel is granted within NCH transfers.
- rdata_o holds its value after done until the next capture; only done_o qualifies it.

Test Plan:
- NCH=2, ch0 4-byte read at 0x100, RAM bytes 11,22,33,44 -> mem_a 0x100..0x103 in cycles 1–4; done_o[0] in cycle 6; rdata_o=0x44332211.
- ch1 2-byte write 0xBEEF at 0x200 -> mem_wr=1 with mem_a/mem_dout (0x200,EF), (0x201,BE) in cycles 1–2; done_o[1] in cycle 3; no extra write.
- ch0 and ch1 both request continuously, RR_MODE=0 -> ch0 always granted, ch1 starves. RR_MODE=1 -> grants alternate 0,1,0,1.
- 4-byte read with rdy_in low for 3 cycles after the 2nd issue -> no issue and mem_wr=0 during the pause; byte 1 still captured; each address issued once; correct rdata_o; done delayed by 3 cycles.
- 1-byte read from 0x30000 returning 0x41 -> exactly one bus access to 0x30000; rdata_o=0x00000041.
- rst_in low during the 3rd issue of a write -> all outputs 0 immediately; no done_o; after release, a new request proceeds normally.
